qu_ic_issue_sched: RTL and testbench
====================================

QU_IC_ISSUE_SCHED -- requirements
Module: qu_ic_issue_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of issue-queue entries (2..8).
REQ-002 SHALL take UOP_WIDTH and PHY_RF_ADDR_WIDTH from the qu_uop/qu_common packages; they are not parameters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, discard all queued and staged uops.
REQ-006 SHALL have port disp_valid, input, 1, dispatch offers a uop.
REQ-007 SHALL have port disp_ready, output, 1, queue can accept (combinational, = not full).
REQ-008 SHALL have port disp_uop, input, UOP_WIDTH, uop_t read as its uop_ic view.
REQ-009 SHALL have port disp_rs1_rdy, input, 1, rs1 value available at dispatch.
REQ-010 SHALL have port disp_rs2_rdy, input, 1, rs2 value available at dispatch.
REQ-011 SHALL have port wb_valid, input, 1, writeback broadcast valid.
REQ-012 SHALL have port wb_tag, input, PHY_RF_ADDR_WIDTH, physical register being written.
REQ-013 SHALL have port iss_valid, output, 1, iss_uop holds an issuable uop.
REQ-014 SHALL have port iss_ready, input, 1, ALU accepts iss_uop this cycle.
REQ-015 SHALL have port iss_uop, output, UOP_WIDTH, uop sent to the ALU.
REQ-016 SHALL have port count, output, $clog2(DEPTH+1), number of occupied queue entries.
REQ-017 SHALL have port bad_optype, output, 1, one-cycle pulse when a LOAD/STORE uop is dropped.

Function
REQ-018 SHALL hold entries in a collapsing queue: index 0 oldest; each entry stores valid, uop, r1, r2.
REQ-019 SHALL accept a dispatch when disp_valid && disp_ready; the uop is written at the lowest free index after this cycle's removal collapse.
REQ-020 SHALL drop an accepted uop whose optype is OPTYPE_LOAD or OPTYPE_STORE and pulse bad_optype for the next cycle; the dropped uop is not enqueued.
REQ-021 SHALL set entry r1 = !rs1_valid || disp_rs1_rdy || (wb_valid && wb_tag == rs1) on insert; r2 is set the same way from the rs2 fields.
REQ-022 SHALL set r1 (r2) of every valid entry when wb_valid && wb_tag equals its rs1 (rs2) and rs1_valid (rs2_valid) is set.
REQ-023 SHALL treat an entry as ready when r1 && r2 hold in the current cycle; a wakeup takes effect from the following cycle.
REQ-024 SHALL have a one-deep output stage (iss_valid/iss_uop); it may load when !iss_valid || iss_ready.
REQ-025 SHALL, when the stage may load, move the lowest-index ready entry into it and shift higher entries down by one in the same edge.
REQ-026 SHALL hold iss_uop stable while iss_valid && !iss_ready, and SHALL NOT remove any entry in that cycle.
REQ-027 SHALL clear iss_valid on iss_ready when no entry is ready.
REQ-028 SHALL give a uop dispatched in cycle N with both operands ready a minimum latency of iss_valid=1 in cycle N+2.
REQ-029 SHALL keep disp_ready = (count < DEPTH); a simultaneous removal does not raise disp_ready in the same cycle.
REQ-030 SHALL allow insert and removal in the same edge; count = count + ins - rem.
REQ-031 SHALL, on flush, clear all entries, iss_valid and bad_optype at the next edge, ignoring that cycle's dispatch and issue; flush has priority over all other events.
REQ-032 SHALL pass the uop fields unmodified from dispatch to iss_uop.

Reset
REQ-033 SHALL, with rst high at an edge, clear all entry valid bits, r1/r2, iss_valid, bad_optype and count to 0; iss_uop is set to all-zero.
REQ-034 SHALL make disp_ready 1 in the first cycle after reset release.
REQ-035 SHALL give rst priority over flush, dispatch and wakeup, including mid-stall with iss_valid=1.

Verification
REQ-036 Ready ALU add (rs1=5, rs2=6, both rdy) dispatched cycle 0, iss_ready=1 -> iss_valid=1 with the same uop in cycle 2; count returns to 0.
REQ-037 Uop A waiting on p9, then ready uop B -> B issues first; wb_valid with wb_tag=9 -> A issues two cycles later.
REQ-038 Same cycle: dispatch of uop with rs1=12 unready and wb_tag=12 -> captured ready and issues in cycle N+2.
REQ-039 DEPTH=4 filled with unready uops -> disp_ready=0 and count=4; wakeup of all four with iss_ready=1 -> issues in age order, one per cycle.
REQ-040 iss_ready=0 for 3 cycles with iss_valid=1 -> iss_uop constant and count unchanged; flush -> iss_valid=0 and count=0 next cycle.
REQ-041 Dispatch of OPTYPE_STORE -> bad_optype=1 for exactly one cycle, count unchanged, nothing issued.

Source files
------------

// File: rtl/qu_ic_issue_sched.sv
// Integer-cluster issue scheduler: a collapsing, age-ordered issue queue with
// writeback wakeup and a one-deep output stage feeding the ALU.
package qu_common;
    localparam int PHY_RF_ADDR_WIDTH = 6;
endpackage

package qu_uop;
    import qu_common::*;

    typedef enum logic [2:0] {
        OPTYPE_ALU    = 3'd0,
        OPTYPE_BRANCH = 3'd1,
        OPTYPE_LOAD   = 3'd2,
        OPTYPE_STORE  = 3'd3,
        OPTYPE_MUL    = 3'd4
    } optype_e;

    typedef struct packed {
        optype_e                        optype;
        logic [3:0]                     op;
        logic                           rs1_valid;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rs1;
        logic                           rs2_valid;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rs2;
        logic                           rd_valid;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rd;
        logic [31:0]                    imm;
    } uop_ic_t;

    localparam int UOP_WIDTH = $bits(uop_ic_t);
    typedef logic [UOP_WIDTH-1:0] uop_t;
endpackage

module qu_ic_issue_sched
    import qu_common::*;
    import qu_uop::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            disp_valid,
    output logic                            disp_ready,
    input  logic [UOP_WIDTH-1:0]            disp_uop,
    input  logic                            disp_rs1_rdy,
    input  logic                            disp_rs2_rdy,
    input  logic                            wb_valid,
    input  logic [PHY_RF_ADDR_WIDTH-1:0]    wb_tag,
    output logic                            iss_valid,
    input  logic                            iss_ready,
    output logic [UOP_WIDTH-1:0]            iss_uop,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            bad_optype
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   r1_q, r1_d;
    logic [DEPTH-1:0]   r2_q, r2_d;
    uop_t               uop_q [DEPTH];
    uop_t               uop_d [DEPTH];
    logic               iss_valid_q, iss_valid_d;
    uop_t               iss_uop_q, iss_uop_d;
    logic               bad_optype_q, bad_optype_d;
    logic [CW-1:0]      count_q, count_d;

    uop_ic_t            disp_ic;
    logic [DEPTH-1:0]   wk1, wk2, rdy_vec;
    logic [IW-1:0]      sel;
    logic               any_rdy;
    logic               stage_load, rem, is_mem, disp_acc, ins, ins_r1, ins_r2;
    logic [CW-1:0]      ins_idx;
    logic [DEPTH:0]     sh_v, sh_1, sh_2;
    uop_t               sh_u [DEPTH+1];

    assign disp_ic    = uop_ic_t'(disp_uop);
    assign disp_ready = (count_q < CW'(DEPTH));

    // Wakeup updates the stored ready bits; readiness for selection uses only
    // the registered bits so a broadcast takes effect one cycle later.
    always_comb begin
        uop_ic_t ent;
        ent = '0;
        wk1 = '0;
        wk2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent    = uop_ic_t'(uop_q[i]);
            wk1[i] = valid_q[i] & (r1_q[i] | (wb_valid && ent.rs1_valid && wb_tag == ent.rs1));
            wk2[i] = valid_q[i] & (r2_q[i] | (wb_valid && ent.rs2_valid && wb_tag == ent.rs2));
        end
    end

    always_comb begin
        rdy_vec = valid_q & r1_q & r2_q;
        sel     = '0;
        any_rdy = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy_vec[i]) begin
                sel     = IW'(i);
                any_rdy = 1'b1;
            end
        end
    end

    always_comb begin
        stage_load = !iss_valid_q || iss_ready;
        rem        = stage_load && any_rdy;
        is_mem     = (disp_ic.optype == OPTYPE_LOAD) || (disp_ic.optype == OPTYPE_STORE);
        disp_acc   = disp_valid && disp_ready;
        ins        = disp_acc && !is_mem;
        ins_idx    = count_q - CW'(rem);
        ins_r1     = !disp_ic.rs1_valid || disp_rs1_rdy || (wb_valid && wb_tag == disp_ic.rs1);
        ins_r2     = !disp_ic.rs2_valid || disp_rs2_rdy || (wb_valid && wb_tag == disp_ic.rs2);

        sh_v = {1'b0, valid_q};
        sh_1 = {1'b0, wk1};
        sh_2 = {1'b0, wk2};
        for (int i = 0; i < DEPTH; i++) sh_u[i] = uop_q[i];
        sh_u[DEPTH] = '0;

        // Entries above the removed one slide down by one; the new uop lands
        // just past the surviving entries.
        for (int i = 0; i < DEPTH; i++) begin
            if (rem && (i >= int'(sel))) begin
                valid_d[i] = sh_v[i+1];
                r1_d[i]    = sh_1[i+1];
                r2_d[i]    = sh_2[i+1];
                uop_d[i]   = sh_u[i+1];
            end else begin
                valid_d[i] = sh_v[i];
                r1_d[i]    = sh_1[i];
                r2_d[i]    = sh_2[i];
                uop_d[i]   = sh_u[i];
            end
            if (ins && (CW'(i) == ins_idx)) begin
                valid_d[i] = 1'b1;
                r1_d[i]    = ins_r1;
                r2_d[i]    = ins_r2;
                uop_d[i]   = disp_uop;
            end
        end

        iss_valid_d = iss_valid_q;
        iss_uop_d   = iss_uop_q;
        if (stage_load) begin
            iss_valid_d = any_rdy;
            if (any_rdy) iss_uop_d = uop_q[sel];
        end

        bad_optype_d = disp_acc && is_mem;
        count_d      = count_q + CW'(ins) - CW'(rem);

        if (flush) begin
            valid_d      = '0;
            r1_d         = '0;
            r2_d         = '0;
            iss_valid_d  = 1'b0;
            bad_optype_d = 1'b0;
            count_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            r1_q         <= '0;
            r2_q         <= '0;
            iss_valid_q  <= 1'b0;
            iss_uop_q    <= '0;
            bad_optype_q <= 1'b0;
            count_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            iss_valid_q  <= iss_valid_d;
            iss_uop_q    <= iss_uop_d;
            bad_optype_q <= bad_optype_d;
            count_q      <= count_d;
        end
    end

    // Payload storage needs no reset: valid bits qualify every entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) uop_q[i] <= uop_d[i];
    end

    assign iss_valid  = iss_valid_q;
    assign iss_uop    = iss_uop_q;
    assign count      = count_q;
    assign bad_optype = bad_optype_q;

endmodule

// File: tb/tb_qu_ic_issue_sched.sv
// Directed self-checking bench for qu_ic_issue_sched (DEPTH=4).
module tb_qu_ic_issue_sched;
    import qu_uop::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, disp_valid, disp_ready, disp_rs1_rdy, disp_rs2_rdy;
    logic        wb_valid, iss_valid, iss_ready, bad_optype;
    logic [5:0]  wb_tag;
    uop_t        disp_uop, iss_uop;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_pass = 0;

    uop_t ua, ub, uc, ue, uf, ug, uh, us;
    uop_t ud [4];

    always #5 clk = ~clk;

    qu_ic_issue_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_uop(disp_uop),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_uop(iss_uop),
        .count(count), .bad_optype(bad_optype)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic uop_t mk_uop(input optype_e ot, input logic v1, input logic [5:0] s1,
                                    input logic v2, input logic [5:0] s2, input logic [31:0] imm);
        uop_ic_t u;
        u.optype    = ot;
        u.op        = 4'h3;
        u.rs1_valid = v1;
        u.rs1       = s1;
        u.rs2_valid = v2;
        u.rs2       = s2;
        u.rd_valid  = 1'b1;
        u.rd        = 6'd40;
        u.imm       = imm;
        return uop_t'(u);
    endfunction

    task automatic dispatch(input uop_t u, input logic r1, input logic r2);
        disp_valid   = 1'b1;
        disp_uop     = u;
        disp_rs1_rdy = r1;
        disp_rs2_rdy = r2;
    endtask

    task automatic idle();
        disp_valid   = 1'b0;
        disp_uop     = '0;
        disp_rs1_rdy = 1'b0;
        disp_rs2_rdy = 1'b0;
        wb_valid     = 1'b0;
        wb_tag       = '0;
        flush        = 1'b0;
    endtask

    initial begin
        ua = mk_uop(OPTYPE_ALU, 1'b1, 6'd5,  1'b1, 6'd6,  32'h0000_00A1);
        ub = mk_uop(OPTYPE_ALU, 1'b1, 6'd1,  1'b1, 6'd2,  32'h0000_00B2);
        uc = mk_uop(OPTYPE_ALU, 1'b1, 6'd12, 1'b1, 6'd13, 32'h0000_00C3);
        ue = mk_uop(OPTYPE_ALU, 1'b0, 6'd0,  1'b0, 6'd0,  32'h0000_00E5);
        uf = mk_uop(OPTYPE_MUL, 1'b1, 6'd3,  1'b0, 6'd0,  32'h0000_00F6);
        ug = mk_uop(OPTYPE_ALU, 1'b0, 6'd0,  1'b1, 6'd4,  32'h0000_0A07);
        uh = mk_uop(OPTYPE_ALU, 1'b0, 6'd0,  1'b0, 6'd0,  32'h0000_0B08);
        us = mk_uop(OPTYPE_STORE, 1'b1, 6'd7, 1'b1, 6'd8, 32'h0000_0C09);
        for (int i = 0; i < 4; i++)
            ud[i] = mk_uop(OPTYPE_ALU, 1'b1, 6'd20, 1'b0, 6'd0, 32'h0000_0D00 + 32'(i));

        rst = 1'b1;
        iss_ready = 1'b1;
        idle();
        tick();
        tick();
        check_val("rst_iss_valid", 64'(iss_valid), 64'd0);
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_bad", 64'(bad_optype), 64'd0);
        check_val("rst_iss_uop", 64'(iss_uop), 64'd0);
        rst = 1'b0;
        check_val("rst_disp_ready", 64'(disp_ready), 64'd1);

        // Ready uop: issue two cycles after dispatch.
        dispatch(ua, 1'b1, 1'b1);
        tick();
        idle();
        check_val("t1_count_c1", 64'(count), 64'd1);
        check_val("t1_iss_valid_c1", 64'(iss_valid), 64'd0);
        tick();
        check_val("t1_iss_valid_c2", 64'(iss_valid), 64'd1);
        check_val("t1_iss_uop_c2", 64'(iss_uop), 64'(ua));
        check_val("t1_count_c2", 64'(count), 64'd0);
        tick();
        check_val("t1_iss_valid_c3", 64'(iss_valid), 64'd0);

        // Older waiting uop is bypassed by a younger ready one.
        dispatch(mk_uop(OPTYPE_ALU, 1'b1, 6'd9, 1'b0, 6'd0, 32'h0000_0A0A), 1'b0, 1'b0);
        tick();
        dispatch(ub, 1'b1, 1'b1);
        tick();
        idle();
        check_val("t2_count_c2", 64'(count), 64'd2);
        tick();
        check_val("t2_b_valid", 64'(iss_valid), 64'd1);
        check_val("t2_b_uop", 64'(iss_uop), 64'(ub));
        check_val("t2_count_c3", 64'(count), 64'd1);
        wb_valid = 1'b1;
        wb_tag   = 6'd9;
        tick();
        idle();
        check_val("t2_gap_valid", 64'(iss_valid), 64'd0);
        tick();
        check_val("t2_a_valid", 64'(iss_valid), 64'd1);
        check_val("t2_a_uop", 64'(iss_uop),
                  64'(mk_uop(OPTYPE_ALU, 1'b1, 6'd9, 1'b0, 6'd0, 32'h0000_0A0A)));
        check_val("t2_count_c5", 64'(count), 64'd0);
        tick();

        // Writeback on the dispatch cycle is captured at insert.
        dispatch(uc, 1'b0, 1'b1);
        wb_valid = 1'b1;
        wb_tag   = 6'd12;
        tick();
        idle();
        tick();
        check_val("t3_valid", 64'(iss_valid), 64'd1);
        check_val("t3_uop", 64'(iss_uop), 64'(uc));
        tick();

        // Fill with waiting uops, refuse a fifth, then wake all at once.
        for (int i = 0; i < 4; i++) begin
            dispatch(ud[i], 1'b0, 1'b0);
            tick();
        end
        check_val("t4_full_count", 64'(count), 64'd4);
        check_val("t4_full_ready", 64'(disp_ready), 64'd0);
        dispatch(ue, 1'b1, 1'b1);
        tick();
        idle();
        check_val("t4_refused_count", 64'(count), 64'd4);
        wb_valid = 1'b1;
        wb_tag   = 6'd20;
        tick();
        idle();
        check_val("t4_woke_valid", 64'(iss_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("t4_age_valid%0d", i), 64'(iss_valid), 64'd1);
            check_val($sformatf("t4_age_uop%0d", i), 64'(iss_uop), 64'(ud[i]));
            check_val($sformatf("t4_age_count%0d", i), 64'(count), 64'(3 - i));
        end
        tick();
        check_val("t4_drained", 64'(iss_valid), 64'd0);

        // Stall holds the stage and the queue; flush clears both.
        iss_ready = 1'b0;
        dispatch(uf, 1'b1, 1'b1);
        tick();
        dispatch(ug, 1'b1, 1'b1);
        tick();
        idle();
        check_val("t5_stall_valid", 64'(iss_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("t5_stall_uop%0d", i), 64'(iss_uop), 64'(uf));
            check_val($sformatf("t5_stall_count%0d", i), 64'(count), 64'd1);
        end
        flush = 1'b1;
        dispatch(uh, 1'b1, 1'b1);
        tick();
        idle();
        check_val("t5_flush_valid", 64'(iss_valid), 64'd0);
        check_val("t5_flush_count", 64'(count), 64'd0);
        iss_ready = 1'b1;
        tick();
        check_val("t5_post_flush_valid", 64'(iss_valid), 64'd0);

        // Memory op is dropped with a single-cycle pulse.
        dispatch(us, 1'b1, 1'b1);
        tick();
        idle();
        check_val("t6_bad_pulse", 64'(bad_optype), 64'd1);
        check_val("t6_count", 64'(count), 64'd0);
        tick();
        check_val("t6_bad_clear", 64'(bad_optype), 64'd0);
        check_val("t6_no_issue", 64'(iss_valid), 64'd0);
        tick();
        check_val("t6_no_issue_late", 64'(iss_valid), 64'd0);

        // Reset beats flush, dispatch and wakeup during a stall.
        iss_ready = 1'b0;
        dispatch(uf, 1'b1, 1'b1);
        tick();
        dispatch(ug, 1'b1, 1'b1);
        tick();
        check_val("t7_stalled", 64'(iss_valid), 64'd1);
        rst      = 1'b1;
        flush    = 1'b1;
        dispatch(uh, 1'b1, 1'b1);
        wb_valid = 1'b1;
        wb_tag   = 6'd4;
        tick();
        check_val("t7_rst_valid", 64'(iss_valid), 64'd0);
        check_val("t7_rst_count", 64'(count), 64'd0);
        check_val("t7_rst_uop", 64'(iss_uop), 64'd0);
        check_val("t7_rst_bad", 64'(bad_optype), 64'd0);
        rst = 1'b0;
        idle();
        iss_ready = 1'b1;
        check_val("t7_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        tick();
        check_val("t7_after_valid", 64'(iss_valid), 64'd0);
        check_val("t7_after_count", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
